// File: rtl/vx_stream_rr_arb.sv
// N-to-1 round-robin valid/ready stream arbiter; grant is locked while stalled.
// Optional perf counters via `define VX_STREAM_RR_ARB_PERF_EN.
module vx_stream_rr_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int SEL_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [SEL_W-1:0]          sel_out,
  input  logic                      ready_out
`ifdef VX_STREAM_RR_ARB_PERF_EN
  ,
  output logic [31:0]               perf_stalls,
  output logic [31:0]               perf_conflicts
`endif
);

  if (NUM_REQS == 1) begin : g_passthru
    assign valid_out = valid_in[0];
    assign ready_in  = ready_out;
    assign data_out  = data_in;
    assign sel_out   = '0;
  end else begin : g_arb
    typedef enum logic {ST_ARB, ST_HOLD} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] rr_ptr, rr_ptr_d;
    logic [SEL_W-1:0] lock_idx, lock_idx_d;
    logic [SEL_W-1:0] grant;
    logic             lock_valid;
    logic             vout;

    // Scan distances from farthest to nearest so the nearest valid stream wins.
    always_comb begin
      grant      = '0;
      lock_valid = 1'b0;
      if (state_q == ST_HOLD) begin
        grant = lock_idx;
        for (int unsigned j = 0; j < NUM_REQS; j++)
          if (lock_idx == SEL_W'(j)) lock_valid = valid_in[j];
      end else begin
        for (int unsigned k = NUM_REQS; k >= 1; k--)
          for (int unsigned j = 0; j < NUM_REQS; j++)
            if (valid_in[j] && (j == (32'(rr_ptr) + k) % NUM_REQS))
              grant = SEL_W'(j);
      end
    end

    assign vout = !reset && ((state_q == ST_HOLD) ? lock_valid : |valid_in);

    always_comb begin
      data_out = '0;
      ready_in = '0;
      for (int unsigned j = 0; j < NUM_REQS; j++) begin
        if (grant == SEL_W'(j)) begin
          data_out    = data_in[j*DATAW +: DATAW];
          ready_in[j] = ready_out & vout;
        end
      end
    end

    assign valid_out = vout;
    assign sel_out   = grant;

    always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr;
      lock_idx_d = lock_idx;
      if (vout && ready_out) begin
        rr_ptr_d = grant;
        state_d  = ST_ARB;
      end else if (vout) begin
        state_d    = ST_HOLD;
        lock_idx_d = grant;
      end else if (state_q == ST_HOLD) begin
        // Held stream withdrew its request: release so arbitration resumes.
        state_d = ST_ARB;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_ARB;
        rr_ptr   <= SEL_W'(NUM_REQS - 1);
        lock_idx <= '0;
      end else begin
        state_q  <= state_d;
        rr_ptr   <= rr_ptr_d;
        lock_idx <= lock_idx_d;
      end
    end
  end

`ifdef VX_STREAM_RR_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls    <= '0;
      perf_conflicts <= '0;
    end else begin
      if (valid_out && !ready_out)
        perf_stalls <= perf_stalls + 32'd1;
      if (valid_out && ready_out && ($countones(valid_in) >= 2))
        perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_stream_rr_arb.sv
// Directed table-driven bench for vx_stream_rr_arb (4-stream and 3-stream instances).
module tb_vx_stream_rr_arb;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   vin4;
  logic [127:0] din4;
  logic [3:0]   rin4;
  logic         vout4;
  logic [31:0]  dout4;
  logic [1:0]   sel4;
  logic         rdy4;

  logic [2:0]   vin3;
  logic [23:0]  din3;
  logic [2:0]   rin3;
  logic         vout3;
  logic [7:0]   dout3;
  logic [1:0]   sel3;
  logic         rdy3;

`ifdef VX_STREAM_RR_ARB_PERF_EN
  logic [31:0]  stalls4, confl4, stalls3, confl3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vx_stream_rr_arb #(.NUM_REQS(4), .DATAW(32)) dut4 (
    .clk(clk), .reset(reset), .valid_in(vin4), .data_in(din4), .ready_in(rin4),
    .valid_out(vout4), .data_out(dout4), .sel_out(sel4), .ready_out(rdy4)
`ifdef VX_STREAM_RR_ARB_PERF_EN
    , .perf_stalls(stalls4), .perf_conflicts(confl4)
`endif
  );

  vx_stream_rr_arb #(.NUM_REQS(3), .DATAW(8)) dut3 (
    .clk(clk), .reset(reset), .valid_in(vin3), .data_in(din3), .ready_in(rin3),
    .valid_out(vout3), .data_out(dout3), .sel_out(sel3), .ready_out(rdy3)
`ifdef VX_STREAM_RR_ARB_PERF_EN
    , .perf_stalls(stalls3), .perf_conflicts(confl3)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] vin;
    logic       rdy;
    logic       exp_v;
    logic [1:0] exp_sel;
    logic [3:0] exp_rin;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] vin, input logic rdy,
                     input logic ev, input logic [1:0] es, input logic [3:0] er);
    vec_t v;
    v.rst = rst; v.vin = vin; v.rdy = rdy; v.exp_v = ev; v.exp_sel = es; v.exp_rin = er;
    vecs.push_back(v);
  endtask

  task automatic step3(input int idx, input logic [2:0] vin, input logic rdy,
                       input logic ev, input logic [1:0] es, input logic [2:0] er);
    @(negedge clk);
    vin3 = vin; rdy3 = rdy;
    #1;
    check("n3_valid", idx, 32'(vout3), 32'(ev));
    check("n3_ready_in", idx, 32'(rin3), 32'(er));
    if (ev) begin
      check("n3_sel", idx, 32'(sel3), 32'(es));
      check("n3_data", idx, 32'(dout3), 32'h30 + 32'(es));
    end
  endtask

  initial begin
    reset = 1'b1; vin4 = '0; rdy4 = 1'b0; vin3 = '0; rdy3 = 1'b0;
    for (int i = 0; i < 4; i++) din4[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
    for (int i = 0; i < 3; i++) din3[i*8 +: 8] = 8'h30 + 8'(i);

    // reset state
    add(1, 4'b1111, 1, 0, 0, 4'b0000);
    // full rotation, all streams requesting
    for (int i = 0; i < 8; i++) add(0, 4'b1111, 1, 1, 2'(i % 4), 4'b0001 << (i % 4));
    // stall on stream 2, higher-priority stream 0 arrives, then accept; next grant wraps to 0
    add(0, 4'b0100, 0, 1, 2, 4'b0000);
    add(0, 4'b0101, 0, 1, 2, 4'b0000);
    add(0, 4'b0101, 0, 1, 2, 4'b0000);
    add(0, 4'b0101, 1, 1, 2, 4'b0100);
    add(0, 4'b0001, 1, 1, 0, 4'b0001);
    // idle with ready_out toggling; pointer (0) must be untouched
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 1'(i % 2), 0, 0, 4'b0000);
    add(0, 4'b1111, 1, 1, 1, 4'b0010);
    // locked stream 3 withdraws valid: valid_out falls, lock releases, pointer stays 1
    add(0, 4'b1000, 0, 1, 3, 4'b0000);
    add(0, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0001, 1, 1, 0, 4'b0001);
    // reset during a locked stall on stream 3
    add(0, 4'b1000, 0, 1, 3, 4'b0000);
    add(0, 4'b1001, 0, 1, 3, 4'b0000);
    add(1, 4'b1001, 1, 0, 0, 4'b0000);
    add(0, 4'b1001, 1, 1, 0, 4'b0001);
    add(0, 4'b1001, 1, 1, 3, 4'b1000);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; vin4 = vecs[i].vin; rdy4 = vecs[i].rdy;
      #1;
      check("valid_out", i, 32'(vout4), 32'(vecs[i].exp_v));
      check("ready_in", i, 32'(rin4), 32'(vecs[i].exp_rin));
      if (vecs[i].exp_v) begin
        check("sel_out", i, 32'(sel4), 32'(vecs[i].exp_sel));
        check("data_out", i, dout4, 32'hC0DE_0000 | 32'(vecs[i].exp_sel));
      end
    end

    // 3-stream wrap on a non-power-of-two count
    @(negedge clk); reset = 1'b1; vin4 = '0; rdy4 = 1'b0;
    @(negedge clk); reset = 1'b0;
    step3(0, 3'b010, 1, 1, 1, 3'b010);
    step3(1, 3'b100, 1, 1, 2, 3'b100);
    step3(2, 3'b111, 1, 1, 0, 3'b001);
    step3(3, 3'b111, 1, 1, 1, 3'b010);
    step3(4, 3'b111, 1, 1, 2, 3'b100);
    step3(5, 3'b111, 1, 1, 0, 3'b001);

`ifdef VX_STREAM_RR_ARB_PERF_EN
    @(negedge clk); reset = 1'b1; vin3 = '0; rdy3 = 1'b0;
    #1;
    @(negedge clk); reset = 1'b0;
    #1;
    check("perf_stalls_rst", 0, stalls4, 32'd0);
    check("perf_conflicts_rst", 0, confl4, 32'd0);
    for (int i = 0; i < 4; i++) begin
      vin4 = 4'b0011; rdy4 = 1'b0;
      @(negedge clk);
    end
    vin4 = 4'b0011; rdy4 = 1'b1;
    @(negedge clk);
    vin4 = 4'b0010; rdy4 = 1'b1;
    @(negedge clk);
    vin4 = 4'b0000; rdy4 = 1'b0;
    #1;
    check("perf_stalls", 1, stalls4, 32'd4);
    check("perf_conflicts", 1, confl4, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
